// File: rtl/ray_tri_if.sv
// ray_tri_if: job/result handshake bundle for ray_tri_intersect_seq.
//   master: producer of jobs / consumer of results (fetch + hit-resolve side)
//   slave : the intersection unit
//   Job side   : in_valid, in_ready, p1..p3, d1..d3, a1..a3, b1..b3, c1..c3, in_tag
//   Result side: out_valid, out_ready, hit, t, u, v, o1..o3, out_tag
interface ray_tri_if #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int TAG_W = 8
);
    logic                    in_valid, in_ready;
    logic signed [WIDTH-1:0] p1, p2, p3, d1, d2, d3;
    logic signed [WIDTH-1:0] a1, a2, a3, b1, b2, b3, c1, c2, c3;
    logic [TAG_W-1:0]        in_tag;
    logic                    out_valid, out_ready, hit;
    logic signed [WIDTH-1:0] t, u, v, o1, o2, o3;
    logic [TAG_W-1:0]        out_tag;

    modport master (
        output in_valid, p1, p2, p3, d1, d2, d3,
               a1, a2, a3, b1, b2, b3, c1, c2, c3, in_tag, out_ready,
        input  in_ready, out_valid, hit, t, u, v, o1, o2, o3, out_tag
    );

    modport slave (
        input  in_valid, p1, p2, p3, d1, d2, d3,
               a1, a2, a3, b1, b2, b3, c1, c2, c3, in_tag, out_ready,
        output in_ready, out_valid, hit, t, u, v, o1, o2, o3, out_tag
    );
endinterface

// File: rtl/ray_tri_intersect_seq.sv
// ray_tri_intersect_seq: sequential Moller-Trumbore ray/triangle test in
// signed Q(WIDTH-FRAC).FRAC fixed point. One job at a time; a single shared
// restoring divider produces u, v and t in turn, with early exit on rejection.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ray_tri_if.slave (job in / result out handshakes, tags)
// Build option:
//   RTI_BACKFACE_CULL_EN - when defined, triangles with determinant a<=0
//   (back-facing) are rejected; otherwise only a==0 (parallel) rejects.
module ray_tri_intersect_seq #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int TAG_W = 8
) (
    input logic      clk,
    input logic      rst,
    ray_tri_if.slave bus
);
    localparam int W  = WIDTH;
    localparam int D  = WIDTH + FRAC;     // divider cycles per quotient
    localparam int PW = 2*WIDTH + 2;      // dot/cross accumulator width
    localparam int MW = 2*WIDTH;
    localparam int CW = $clog2(D);
    localparam logic signed [W-1:0] ONE  = W'(1) << FRAC;
    localparam logic signed [W:0]   ONE1 = (W+1)'(1) << FRAC;

    typedef enum logic [3:0] {
        IDLE, EDGE, CROSS, DOT, DIV_U, DIV_V, DIV_T, POINT, DONE
    } state_t;

    // (x0*y0 + x1*y1 + x2*y2) >>> FRAC, summed at full precision
    function automatic logic signed [W-1:0] dot3(
        input logic signed [W-1:0] x0, x1, x2, y0, y1, y2);
        logic signed [PW-1:0] acc;
        acc = PW'(x0) * PW'(y0) + PW'(x1) * PW'(y1) + PW'(x2) * PW'(y2);
        return W'(acc >>> FRAC);
    endfunction

    // (x0*y0 - x1*y1) >>> FRAC, one cross-product component
    function automatic logic signed [W-1:0] xdiff(
        input logic signed [W-1:0] x0, y0, x1, y1);
        logic signed [PW-1:0] acc;
        acc = PW'(x0) * PW'(y0) - PW'(x1) * PW'(y1);
        return W'(acc >>> FRAC);
    endfunction

    function automatic logic signed [W-1:0] fx_mul(
        input logic signed [W-1:0] x, y);
        logic signed [MW-1:0] m;
        m = MW'(x) * MW'(y);
        return W'(m >>> FRAC);
    endfunction

    state_t              state;
    logic                dot_ph;     // DOT second cycle: dot products are registered
    logic signed [W-1:0] pr [3], dr [3], ar [3], br [3], cr [3];
    logic signed [W-1:0] e1 [3], e2 [3], sr [3], h [3], q [3];
    logic signed [W-1:0] a_r, nu, nv, nt, u_r, v_r, t_r;
    logic [TAG_W-1:0]    tag_r;

    // shared divider state
    logic [W-1:0]  rem;
    logic [D-1:0]  dq;         // dividend shifts out the top, quotient in the bottom
    logic [CW-1:0] cnt;
    logic          div_neg;

    logic [W-1:0]        dvs, src_abs, q_mag, rem_nx;
    logic [W:0]          rem_sh;
    logic [D-1:0]        dq_nx;
    logic                ge, last, src_neg, reject;
    logic signed [W-1:0] div_src, q_val;
    logic signed [W:0]   uv_sum;

    always_comb begin
        dvs     = a_r[W-1] ? -a_r : a_r;
        // numerator for the quotient that starts next
        case (state)
            DOT:     div_src = nu;
            DIV_U:   div_src = nv;
            default: div_src = nt;
        endcase
        src_abs = div_src[W-1] ? -div_src : div_src;
        src_neg = div_src[W-1] ^ a_r[W-1];

        rem_sh  = {rem, dq[D-1]};
        ge      = rem_sh >= {1'b0, dvs};
        rem_nx  = ge ? W'(rem_sh - {1'b0, dvs}) : rem_sh[W-1:0];
        dq_nx   = {dq[D-2:0], ge};
        last    = (cnt == CW'(D-1));

        // quotient including this cycle's bit, saturated then signed
        q_mag   = (|dq_nx[D-1:W-1]) ? {1'b0, {(W-1){1'b1}}} : dq_nx[W-1:0];
        q_val   = div_neg ? -q_mag : q_mag;
        uv_sum  = {u_r[W-1], u_r} + {q_val[W-1], q_val};

        reject = 1'b0;
        case (state)
`ifdef RTI_BACKFACE_CULL_EN
            DOT:   reject = dot_ph && (a_r <= 0);
`else
            DOT:   reject = dot_ph && (a_r == 0);
`endif
            DIV_U: reject = last && ((q_val < 0) || (q_val > ONE));
            DIV_V: reject = last && ((q_val < 0) || (uv_sum > ONE1));
            DIV_T: reject = last && (q_val <= 0);
            default: reject = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            dot_ph  <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                pr[k] <= '0; dr[k] <= '0; ar[k] <= '0; br[k] <= '0; cr[k] <= '0;
                e1[k] <= '0; e2[k] <= '0; sr[k] <= '0; h[k]  <= '0; q[k]  <= '0;
            end
            a_r <= '0; nu <= '0; nv <= '0; nt <= '0;
            u_r <= '0; v_r <= '0; t_r <= '0;
            tag_r   <= '0;
            rem     <= '0;
            dq      <= '0;
            cnt     <= '0;
            div_neg <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.hit <= 1'b0;
            bus.t   <= '0; bus.u  <= '0; bus.v  <= '0;
            bus.o1  <= '0; bus.o2 <= '0; bus.o3 <= '0;
            bus.out_tag <= '0;
        end else if (reject) begin
            // every early exit lands here with a zeroed miss result
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.hit <= 1'b0;
            bus.t   <= '0; bus.u  <= '0; bus.v  <= '0;
            bus.o1  <= '0; bus.o2 <= '0; bus.o3 <= '0;
            bus.out_tag <= tag_r;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    pr[0] <= bus.p1; pr[1] <= bus.p2; pr[2] <= bus.p3;
                    dr[0] <= bus.d1; dr[1] <= bus.d2; dr[2] <= bus.d3;
                    ar[0] <= bus.a1; ar[1] <= bus.a2; ar[2] <= bus.a3;
                    br[0] <= bus.b1; br[1] <= bus.b2; br[2] <= bus.b3;
                    cr[0] <= bus.c1; cr[1] <= bus.c2; cr[2] <= bus.c3;
                    tag_r        <= bus.in_tag;
                    bus.in_ready <= 1'b0;
                    state        <= EDGE;
                end
                EDGE: begin
                    for (int k = 0; k < 3; k++) begin
                        e1[k] <= br[k] - ar[k];
                        e2[k] <= cr[k] - ar[k];
                        sr[k] <= pr[k] - ar[k];
                    end
                    state <= CROSS;
                end
                CROSS: begin
                    h[0] <= xdiff(dr[1], e2[2], dr[2], e2[1]);
                    h[1] <= xdiff(dr[2], e2[0], dr[0], e2[2]);
                    h[2] <= xdiff(dr[0], e2[1], dr[1], e2[0]);
                    q[0] <= xdiff(sr[1], e1[2], sr[2], e1[1]);
                    q[1] <= xdiff(sr[2], e1[0], sr[0], e1[2]);
                    q[2] <= xdiff(sr[0], e1[1], sr[1], e1[0]);
                    dot_ph <= 1'b0;
                    state  <= DOT;
                end
                DOT: begin
                    if (!dot_ph) begin
                        a_r <= dot3(e1[0], e1[1], e1[2], h[0], h[1], h[2]);
                        nu  <= dot3(sr[0], sr[1], sr[2], h[0], h[1], h[2]);
                        nv  <= dot3(dr[0], dr[1], dr[2], q[0], q[1], q[2]);
                        nt  <= dot3(e2[0], e2[1], e2[2], q[0], q[1], q[2]);
                        dot_ph <= 1'b1;
                    end else begin
                        dq      <= {src_abs, {FRAC{1'b0}}};
                        rem     <= '0;
                        cnt     <= '0;
                        div_neg <= src_neg;
                        state   <= DIV_U;
                    end
                end
                DIV_U, DIV_V, DIV_T: begin
                    rem <= rem_nx;
                    dq  <= dq_nx;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        // reload the divider for the next numerator
                        dq      <= {src_abs, {FRAC{1'b0}}};
                        rem     <= '0;
                        cnt     <= '0;
                        div_neg <= src_neg;
                        case (state)
                            DIV_U:   begin u_r <= q_val; state <= DIV_V; end
                            DIV_V:   begin v_r <= q_val; state <= DIV_T; end
                            default: begin t_r <= q_val; state <= POINT; end
                        endcase
                    end
                end
                POINT: begin
                    bus.o1  <= pr[0] + fx_mul(t_r, dr[0]);
                    bus.o2  <= pr[1] + fx_mul(t_r, dr[1]);
                    bus.o3  <= pr[2] + fx_mul(t_r, dr[2]);
                    bus.t   <= t_r;
                    bus.u   <= u_r;
                    bus.v   <= v_r;
                    bus.hit <= 1'b1;
                    bus.out_tag   <= tag_r;
                    bus.out_valid <= 1'b1;
                    state   <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
